hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Pipeline hazard and stall controller: the stall/flush side of operand bypassing.
- Detects hazards that bypassing cannot cover: load-use, variable-latency data-memory wait, taken-branch redirect, and halt.
- Drives freeze, bubble and flush controls into the PC and the FD/DX/XM/MWB pipeline registers.
- Keeps saturating event counters for perf debug.
- Sits beside the decode stage and observes the FD, DX, XM and MWB latches.

Parameters:
CNT_W, 16, width of each event counter
MEM_TIMEOUT, 64, MEM_WAIT cycles before mem_timeout is raised (>=2)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
r1_hdu_FD  in  1  FD instruction reads source 1
r2_hdu_FD  in  1  FD instruction reads source 2
readRegSel1_FD  in  3  FD source-1 register
readRegSel2_FD  in  3  FD source-2 register
memRead_DX  in  1  DX instruction is a load
regWrite_DX  in  1  DX instruction writes a register
writeRegSel_DX  in  3  DX destination register
mem_req_XM  in  1  XM instruction accesses data memory
mem_done  in  1  data memory completes the current XM access this cycle
branch_taken_XM  in  1  XM branch/jump resolved taken (redirect)
halt_MWB  in  1  HALT instruction in MWB
stall_PC  out  1  hold PC
stall_FD  out  1  hold FD latch
stall_DX  out  1  hold DX latch
stall_XM  out  1  hold XM latch
bubble_DX  out  1  load NOP into DX instead of FD contents
flush_FD  out  1  replace FD with NOP
flush_DX  out  1  replace DX with NOP
halted  out  1  core halted
mem_timeout  out  1  sticky memory-timeout error
lu_cnt  out  CNT_W  load-use stall cycles
mem_cnt  out  CNT_W  memory-wait cycles
flush_cnt  out  CNT_W  redirect events

Behaviour:
- States: RUN, MEM_WAIT, HALTED. Reset enters RUN.
- Reset values: all outputs 0, all counters 0, mem_timeout 0, internal wait counter 0.
- Stall/flush outputs are combinational from state plus the current inputs. State and counters update on the clk rising edge.
- load_use = memRead_DX & regWrite_DX & ((r1_hdu_FD & readRegSel1_FD==writeRegSel_DX) | (r2_hdu_FD & readRegSel2_FD==writeRegSel_DX)).
- mem_block = mem_req_XM & ~mem_done.
- RUN, priority mem_block > branch_taken_XM > load_use:
  - mem_block: assert stall_PC/FD/DX/XM. Next state MEM_WAIT. mem_cnt += 1.
  - else branch_taken_XM: assert flush_FD and flush_DX. No stalls; a coincident load_use is discarded. flush_cnt += 1.
  - else load_use: assert stall_PC, stall_FD, bubble_DX for exactly one cycle. lu_cnt += 1. The next cycle the load is in XM and the consumer is still in FD; it re-checks against the bubble (no match).
- MEM_WAIT:
  - stall_PC/FD/DX/XM asserted every cycle while mem_done=0. mem_cnt += 1 per cycle.
  - Cycle with mem_done=1: no freeze. The pipeline advances and the RUN rules (branch flush, load_use) evaluate this same cycle. Next state RUN.
  - Internal wait counter increments each MEM_WAIT cycle. On reaching MEM_TIMEOUT, set mem_timeout (sticky until rst). Stalls continue.
  - branch_taken_XM held during MEM_WAIT is acted on only in the mem_done cycle.
- HALTED:
  - Entered from any state when halt_MWB=1, taking priority over all other transitions.
  - halted=1, stall_PC/FD/DX/XM=1, no flush/bubble.
  - Counters freeze. Only rst exits.
- Counters saturate at all-ones; no wrap.
- rst mid-MEM_WAIT or mid-HALTED: state RUN and all outputs 0 on the next edge; a pending mem_done is ignored.

Test Plan:
- Load to R3 in DX, FD reads R3 via src2 (r2_hdu_FD=1) -> cycle 0: stall_PC=stall_FD=bubble_DX=1; cycle 1: all 0; lu_cnt=1.
- Same as above but r2_hdu_FD=0, or regWrite_DX=0, or writeRegSel_DX=R4 -> no stall; lu_cnt=0.
- mem_req_XM=1, mem_done low 3 cycles then high -> stalls high cycles 0-2, low cycle 3; state RUN at cycle 4; mem_cnt=3.
- branch_taken_XM=1 and load_use=1 same cycle -> flush_FD=flush_DX=1, bubble_DX=0; flush_cnt=1, lu_cnt=0.
- MEM_TIMEOUT=4, mem_done held 0 for 6 cycles -> mem_timeout rises after 4th MEM_WAIT cycle, stays 1; rst clears it and all counters.
- halt_MWB=1 during MEM_WAIT -> halted=1 next cycle, all stalls 1 indefinitely, counters frozen; rst -> RUN, halted=0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, data-memory wait freezes,
// taken-branch flushes and halt, plus saturating perf counters.
module hazard_stall_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r1_hdu_FD,
    input  logic             r2_hdu_FD,
    input  logic [2:0]       readRegSel1_FD,
    input  logic [2:0]       readRegSel2_FD,
    input  logic             memRead_DX,
    input  logic             regWrite_DX,
    input  logic [2:0]       writeRegSel_DX,
    input  logic             mem_req_XM,
    input  logic             mem_done,
    input  logic             branch_taken_XM,
    input  logic             halt_MWB,
    output logic             stall_PC,
    output logic             stall_FD,
    output logic             stall_DX,
    output logic             stall_XM,
    output logic             bubble_DX,
    output logic             flush_FD,
    output logic             flush_DX,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mem_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {StRun, StMemWait, StHalted} state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] lu_q, lu_d, mem_q, mem_d, flush_q, flush_d;

    logic load_use, mem_block, run_eval, freeze;
    logic lu_inc, mem_inc, flush_inc;

    assign load_use  = memRead_DX & regWrite_DX &
                       ((r1_hdu_FD & (readRegSel1_FD == writeRegSel_DX)) |
                        (r2_hdu_FD & (readRegSel2_FD == writeRegSel_DX)));
    assign mem_block = mem_req_XM & ~mem_done;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        run_eval  = 1'b0;
        freeze    = 1'b0;
        bubble_DX = 1'b0;
        flush_FD  = 1'b0;
        flush_DX  = 1'b0;
        halted    = 1'b0;
        lu_inc    = 1'b0;
        mem_inc   = 1'b0;
        flush_inc = 1'b0;

        unique case (state_q)
            StRun: begin
                run_eval = 1'b1;
                wait_d   = '0;
            end
            StMemWait: begin
                if (!mem_done) begin
                    freeze  = 1'b1;
                    mem_inc = 1'b1;
                    if (wait_q != WaitW'(MEM_TIMEOUT)) wait_d = wait_q + WaitW'(1);
                    if (wait_q >= WaitW'(MEM_TIMEOUT - 1)) timeout_d = 1'b1;
                end else begin
                    // Access completes: pipeline advances and RUN hazards apply now.
                    state_d  = StRun;
                    wait_d   = '0;
                    run_eval = 1'b1;
                end
            end
            StHalted: begin
                freeze = 1'b1;
                halted = 1'b1;
            end
            default: state_d = StRun;
        endcase

        if (run_eval) begin
            if (mem_block) begin
                freeze  = 1'b1;
                mem_inc = 1'b1;
                state_d = StMemWait;
            end else if (branch_taken_XM) begin
                flush_FD  = 1'b1;
                flush_DX  = 1'b1;
                flush_inc = 1'b1;
            end else if (load_use) begin
                bubble_DX = 1'b1;
                lu_inc    = 1'b1;
            end
        end

        if (halt_MWB) state_d = StHalted;

        lu_d    = (lu_inc && lu_q != '1) ? lu_q + CNT_W'(1) : lu_q;
        mem_d   = (mem_inc && mem_q != '1) ? mem_q + CNT_W'(1) : mem_q;
        flush_d = (flush_inc && flush_q != '1) ? flush_q + CNT_W'(1) : flush_q;

        stall_PC = freeze | bubble_DX;
        stall_FD = freeze | bubble_DX;
        stall_DX = freeze;
        stall_XM = freeze;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            lu_q      <= '0;
            mem_q     <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            lu_q      <= lu_d;
            mem_q     <= mem_d;
            flush_q   <= flush_d;
        end
    end

    assign mem_timeout = timeout_q;
    assign lu_cnt      = lu_q;
    assign mem_cnt     = mem_q;
    assign flush_cnt   = flush_q;

endmodule
